surf_mem_arbiter: RTL and testbench

Arbitrates the single port of the SURF input-image BRAM (17-bit address, 48-bit pixel word) between two requesters: the SURF IP core (read-only) and the host image loader (read/write). It issues one registered memory access per cycle and routes read data back to the owner with a tag pipeline that matches the BRAM read latency. Under contention, a bounded-burst round-robin policy guarantees each side forward progress.

---
 rtl/surf_mem_arbiter_if.sv | 38 +++
 rtl/surf_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_surf_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/surf_mem_arbiter_if.sv
// Requester and BRAM-side signals of the SURF image memory arbiter.
// slave = arbiter view, master = requesters/BRAM view.
interface surf_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 48
);
    logic                  ip_req;
    logic [ADDR_WIDTH-1:0] ip_addr;
    logic                  ip_gnt;
    logic [DATA_WIDTH-1:0] ip_rdata;
    logic                  ip_rvalid;

    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic                  ld_gnt;
    logic [DATA_WIDTH-1:0] ld_rdata;
    logic                  ld_rvalid;

    logic                  img_ena;
    logic                  img_wea;
    logic [ADDR_WIDTH-1:0] img_addra;
    logic [DATA_WIDTH-1:0] img_dina;
    logic [DATA_WIDTH-1:0] img_douta;

    modport slave (
        input  ip_req, ip_addr, ld_req, ld_we, ld_addr, ld_wdata, img_douta,
        output ip_gnt, ip_rdata, ip_rvalid, ld_gnt, ld_rdata, ld_rvalid,
               img_ena, img_wea, img_addra, img_dina
    );

    modport master (
        output ip_req, ip_addr, ld_req, ld_we, ld_addr, ld_wdata, img_douta,
        input  ip_gnt, ip_rdata, ip_rvalid, ld_gnt, ld_rdata, ld_rvalid,
               img_ena, img_wea, img_addra, img_dina
    );
endinterface

// File: rtl/surf_mem_arbiter.sv
// IP/loader round-robin arbiter for the SURF image BRAM port; SURF_ARB_STATS_EN adds conflict/stall counters.
// Combinational grant, access registered next cycle, read data RD_LAT later; an ungranted requester holds its request.
module surf_mem_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 48,
    parameter int RD_LAT     = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SURF_ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] conflict_cnt,
    output logic [15:0] ip_stall_cnt,
    output logic [15:0] ld_stall_cnt,
`endif
    surf_mem_arbiter_if.slave bus
);
    typedef enum logic {OWN_LD = 1'b0, OWN_IP = 1'b1} owner_e;
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    owner_e     last_q, last_d;
    logic       streak_q, streak_d;
    logic [7:0] burst_q, burst_d;
    logic       gnt_ip, gnt_ld;
    logic       xfer, rd_xfer;

    logic                  img_ena_q, img_wea_q;
    logic [ADDR_WIDTH-1:0] img_addr_q;
    logic [DATA_WIDTH-1:0] img_din_q;
    logic [RD_LAT:0]       tag_vld, tag_ip;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q   <= OWN_LD;
            streak_q <= 1'b0;
            burst_q  <= '0;
        end else begin
            last_q   <= last_d;
            streak_q <= streak_d;
            burst_q  <= burst_d;
        end
    end

    always_comb begin
        gnt_ip   = 1'b0;
        gnt_ld   = 1'b0;
        last_d   = last_q;
        streak_d = 1'b0;
        burst_d  = '0;
        if (rst) begin
            if (bus.ip_req && bus.ld_req) begin
                // Stay with the current owner only while its unbroken burst is under the limit.
                if (streak_q && (burst_q < BURST_LIMIT)) begin
                    gnt_ip = (last_q == OWN_IP);
                    gnt_ld = (last_q == OWN_LD);
                end else begin
                    gnt_ip = (last_q == OWN_LD);
                    gnt_ld = (last_q == OWN_IP);
                end
            end else begin
                gnt_ip = bus.ip_req;
                gnt_ld = bus.ld_req;
            end
        end
        if (gnt_ip || gnt_ld) begin
            last_d   = gnt_ip ? OWN_IP : OWN_LD;
            streak_d = 1'b1;
            if (streak_q && (last_d == last_q))
                burst_d = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
            else
                burst_d = 8'd1;
        end
    end

    assign xfer    = gnt_ip | gnt_ld;
    assign rd_xfer = gnt_ip | (gnt_ld & ~bus.ld_we);

    always_ff @(posedge clk) begin
        if (!rst) begin
            img_ena_q  <= 1'b0;
            img_wea_q  <= 1'b0;
            img_addr_q <= '0;
            img_din_q  <= '0;
        end else begin
            img_ena_q <= xfer;
            img_wea_q <= gnt_ld & bus.ld_we;
            if (xfer)
                img_addr_q <= gnt_ip ? bus.ip_addr : bus.ld_addr;
            if (gnt_ld && bus.ld_we)
                img_din_q <= bus.ld_wdata;
        end
    end

    // Stage k holds the read issued k+1 cycles ago; the last stage lines up with img_douta.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_vld <= '0;
            tag_ip  <= '0;
        end else begin
            tag_vld <= {tag_vld[RD_LAT-1:0], rd_xfer};
            tag_ip  <= {tag_ip[RD_LAT-1:0], gnt_ip};
        end
    end

`ifdef SURF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || stats_clr) begin
            conflict_cnt <= '0;
            ip_stall_cnt <= '0;
            ld_stall_cnt <= '0;
        end else begin
            if (bus.ip_req && bus.ld_req && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
            if (bus.ip_req && !gnt_ip && (ip_stall_cnt != 16'hFFFF))
                ip_stall_cnt <= ip_stall_cnt + 16'd1;
            if (bus.ld_req && !gnt_ld && (ld_stall_cnt != 16'hFFFF))
                ld_stall_cnt <= ld_stall_cnt + 16'd1;
        end
    end
`endif

    assign bus.ip_gnt    = gnt_ip;
    assign bus.ld_gnt    = gnt_ld;
    assign bus.img_ena   = img_ena_q;
    assign bus.img_wea   = img_wea_q;
    assign bus.img_addra = img_addr_q;
    assign bus.img_dina  = img_din_q;
    assign bus.ip_rdata  = bus.img_douta;
    assign bus.ld_rdata  = bus.img_douta;
    assign bus.ip_rvalid = tag_vld[RD_LAT] & tag_ip[RD_LAT];
    assign bus.ld_rvalid = tag_vld[RD_LAT] & ~tag_ip[RD_LAT];
endmodule

// File: tb/tb_surf_mem_arbiter.sv
// Scoreboard bench for surf_mem_arbiter: directed scenarios then random traffic against a history-based model.
module tb_surf_mem_arbiter;
    localparam int A = 17;
    localparam int D = 48;
    localparam int RD_LAT = 3;
    localparam int MAX_BURST = 4;
    localparam int OWN_IP = 1;
    localparam int OWN_LD = 2;

    typedef struct { int cyc; int own; } gnt_exp_t;
    typedef struct { int cyc; bit we; logic [A-1:0] addr; logic [D-1:0] din; } img_exp_t;
    typedef struct { int cyc; int own; logic [D-1:0] dat; } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    gnt_exp_t gq[$];
    img_exp_t img_q[$];
    rd_exp_t  rd_q[$];
    int       hist[$];
    logic [D-1:0] ref_mem [logic [A-1:0]];
    logic [D-1:0] bram    [logic [A-1:0]];
    logic [D-1:0] dpipe   [RD_LAT];

    surf_mem_arbiter_if #(.ADDR_WIDTH(A), .DATA_WIDTH(D)) mif ();

`ifdef SURF_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] conflict_cnt, ip_stall_cnt, ld_stall_cnt;
`endif

    surf_mem_arbiter #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SURF_ARB_STATS_EN
        .stats_clr(stats_clr),
        .conflict_cnt(conflict_cnt),
        .ip_stall_cnt(ip_stall_cnt),
        .ld_stall_cnt(ld_stall_cnt),
`endif
        .bus(mif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [D-1:0] init_val(input logic [A-1:0] a);
        return {15'h5A5A, a, 16'hC3C3};
    endfunction

    // Behavioural BRAM with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        if (mif.img_ena && mif.img_wea)
            bram[mif.img_addra] = mif.img_dina;
        dpipe[0] <= (mif.img_ena && !mif.img_wea)
                    ? (bram.exists(mif.img_addra) ? bram[mif.img_addra] : init_val(mif.img_addra)) : '0;
        for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign mif.img_douta = dpipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Model: who wins given the history of per-cycle winners (0 = idle).
    function automatic int pick(input bit ipr, input bit ldr);
        int last_own;
        int run;
        if (!ipr && !ldr) return 0;
        if (!ldr) return OWN_IP;
        if (!ipr) return OWN_LD;
        last_own = OWN_LD;
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i] != 0) begin
                last_own = hist[i];
                break;
            end
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last_own; i--) run++;
        return (run > 0 && run < MAX_BURST) ? last_own : (3 - last_own);
    endfunction

    task automatic step(input bit r_n, input bit ipr, input logic [A-1:0] ipa, input bit ldr,
                        input bit ldwe, input logic [A-1:0] lda, input logic [D-1:0] ldd, output int own);
        rd_exp_t keep[$];
        logic [A-1:0] a;
        @(posedge clk);
        #1;
        rst          = r_n;
        mif.ip_req   = ipr;
        mif.ip_addr  = ipa;
        mif.ld_req   = ldr;
        mif.ld_we    = ldwe;
        mif.ld_addr  = lda;
        mif.ld_wdata = ldd;
        own = r_n ? pick(ipr, ldr) : 0;
        gq.push_back('{cyc, own});
        if (own != 0) begin
            a = (own == OWN_IP) ? ipa : lda;
            if (own == OWN_LD && ldwe) begin
                img_q.push_back('{cyc + 1, 1'b1, a, ldd});
                ref_mem[a] = ldd;
            end else begin
                img_q.push_back('{cyc + 1, 1'b0, a, '0});
                rd_q.push_back('{cyc + 1 + RD_LAT, own, ref_mem.exists(a) ? ref_mem[a] : init_val(a)});
            end
        end
        hist.push_back(own);
        if (hist.size() > 1024) void'(hist.pop_front());
        if (!r_n) begin
            hist.delete();
            foreach (rd_q[i]) if (rd_q[i].cyc <= cyc) keep.push_back(rd_q[i]);
            rd_q = keep;
        end
    endtask

    task automatic chk_gnt(input string nm, input int exp_own);
        #1;
        chk(nm, 64'({mif.ip_gnt, mif.ld_gnt}),
            64'((exp_own == OWN_IP) ? 2'b10 : (exp_own == OWN_LD) ? 2'b01 : 2'b00));
    endtask

    task automatic chk_reset_outputs(input string nm);
        @(negedge clk);
        chk({nm, "_ena"}, 64'(mif.img_ena), 64'(0));
        chk({nm, "_wea"}, 64'(mif.img_wea), 64'(0));
        chk({nm, "_addra"}, 64'(mif.img_addra), 64'(0));
        chk({nm, "_dina"}, 64'(mif.img_dina), 64'(0));
        chk({nm, "_rvalid"}, 64'({mif.ip_rvalid, mif.ld_rvalid}), 64'(0));
    endtask

    // Monitor: compares DUT outputs against whatever the stimulus queued for this cycle.
    initial begin
        img_exp_t ie;
        rd_exp_t  re;
        bit due;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    gnt_exp_t g = gq.pop_front();
                    chk("gnt", 64'({mif.ip_gnt, mif.ld_gnt}),
                        64'((g.own == OWN_IP) ? 2'b10 : (g.own == OWN_LD) ? 2'b01 : 2'b00));
                end
                while (img_q.size() > 0 && img_q[0].cyc < cyc) begin
                    void'(img_q.pop_front());
                    n_cmp++; n_bad++;
                    $display("FAIL img_missed @cyc %0d: got no access expected one", cyc);
                end
                due = (img_q.size() > 0 && img_q[0].cyc == cyc);
                chk("img_ena", 64'(mif.img_ena), 64'(due));
                if (due) begin
                    ie = img_q.pop_front();
                    chk("img_wea", 64'(mif.img_wea), 64'(ie.we));
                    chk("img_addra", 64'(mif.img_addra), 64'(ie.addr));
                    if (ie.we) chk("img_dina", 64'(mif.img_dina), 64'(ie.din));
                end else begin
                    chk("img_wea_idle", 64'(mif.img_wea), 64'(0));
                end
                while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                    void'(rd_q.pop_front());
                    n_cmp++; n_bad++;
                    $display("FAIL rd_missed @cyc %0d: got no rvalid expected one", cyc);
                end
                due = (rd_q.size() > 0 && rd_q[0].cyc == cyc);
                re  = due ? rd_q[0] : '{0, 0, '0};
                chk("ip_rvalid", 64'(mif.ip_rvalid), 64'(due && re.own == OWN_IP));
                chk("ld_rvalid", 64'(mif.ld_rvalid), 64'(due && re.own == OWN_LD));
                if (due) begin
                    void'(rd_q.pop_front());
                    chk("rdata", 64'((re.own == OWN_IP) ? mif.ip_rdata : mif.ld_rdata), 64'(re.dat));
                end
            end
        end
    end

    initial begin
        int own, ipn, ldn, rate;
        bit ip_p, ld_p, ld_w;
        logic [A-1:0] ip_a, ld_a;
        logic [D-1:0] ld_d;
        mif.ip_req = 1'b0; mif.ip_addr = '0; mif.ld_req = 1'b0;
        mif.ld_we = 1'b0; mif.ld_addr = '0; mif.ld_wdata = '0;

        // Reset with both requesting: no grants, outputs at reset values.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 17'h5, 1, 1, 17'h7, 48'hDEAD, own);
            chk_gnt("reset_gnt", 0);
        end
        chk_reset_outputs("reset");

        // Continuous conflict straight after reset: IPx4, LDx4, IPx4.
        ipn = 0; ldn = 0;
        for (int k = 0; k < 12; k++) begin
            step(1, 1, A'(32'h20 + ipn), 1, 0, A'(32'h40 + ldn), '0, own);
            chk_gnt("burst_pattern", ((k / 4) % 2 == 0) ? OWN_IP : OWN_LD);
            if (own == OWN_IP) ipn++;
            if (own == OWN_LD) ldn++;
        end
        step(1, 0, '0, 0, 0, '0, '0, own);
`ifdef SURF_ARB_STATS_EN
        @(negedge clk);
        chk("conflict_cnt", 64'(conflict_cnt), 64'(12));
        step(1, 1, 17'h60, 1, 0, 17'h61, '0, own);
        stats_clr = 1'b1;
        step(1, 1, 17'h60, 1, 0, 17'h61, '0, own);
        stats_clr = 1'b0;
        #1;
        chk("conflict_clr", 64'(conflict_cnt), 64'(0));
        step(1, 0, '0, 0, 0, '0, '0, own);
`endif

        // IP-only reads of 0..3, back to back.
        for (int k = 0; k < 4; k++) begin
            step(1, 1, A'(k), 0, 0, '0, '0, own);
            chk_gnt("ip_only_gnt", OWN_IP);
        end

        // Loader write then IP read of the same word.
        step(1, 0, '0, 1, 1, 17'h1ABC, 48'h123456789ABC, own);
        chk_gnt("ld_write_gnt", OWN_LD);
        step(1, 1, 17'h1ABC, 0, 0, '0, '0, own);
        chk_gnt("ip_read_gnt", OWN_IP);

        // An idle cycle breaks the IP streak, so the loader wins the next conflict.
        step(1, 1, 17'h3, 0, 0, '0, '0, own);
        step(1, 0, '0, 0, 0, '0, '0, own);
        step(1, 1, 17'h4, 1, 0, 17'h5, '0, own);
        chk_gnt("idle_gap_gnt", OWN_LD);
        for (int k = 0; k < RD_LAT + 2; k++) step(1, 0, '0, 0, 0, '0, '0, own);

        // Reset one cycle after an IP read grant drops the read.
        step(1, 1, 17'h1ABC, 0, 0, '0, '0, own);
        step(0, 0, '0, 0, 0, '0, '0, own);
        step(1, 0, '0, 0, 0, '0, '0, own);
        chk_reset_outputs("mid_reset");
        for (int k = 0; k < RD_LAT + 2; k++) step(1, 0, '0, 0, 0, '0, '0, own);

        // Random traffic: a busy phase then a sparse one, with occasional withdrawn requests.
        ip_p = 0; ld_p = 0; ld_w = 0; ip_a = '0; ld_a = '0; ld_d = '0;
        for (int n = 0; n < 3000; n++) begin
            rate = (n < 1500) ? 90 : 30;
            if (!ip_p && $urandom_range(99) < rate) begin
                ip_p = 1;
                ip_a = A'($urandom_range(0, 15) + ($urandom_range(0, 1) ? 32'h1FFF0 : 32'h0));
            end else if (ip_p && $urandom_range(99) < 5) ip_p = 0;
            if (!ld_p && $urandom_range(99) < rate) begin
                ld_p = 1;
                ld_w = 1'($urandom_range(0, 1));
                ld_a = A'($urandom_range(0, 15) + ($urandom_range(0, 1) ? 32'h1FFF0 : 32'h0));
                ld_d = D'({$urandom(), $urandom()});
            end else if (ld_p && $urandom_range(99) < 5) ld_p = 0;
            step(1, ip_p, ip_a, ld_p, ld_w, ld_a, ld_d, own);
            if (own == OWN_IP) ip_p = 0;
            if (own == OWN_LD) ld_p = 0;
        end

        for (int k = 0; k < RD_LAT + 4; k++) step(1, 0, '0, 0, 0, '0, '0, own);
        @(negedge clk);
        #1;
        chk("img_q_drained", 64'(img_q.size()), 64'(0));
        chk("rd_q_drained", 64'(rd_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
